// File: rtl/msx_bus_master.sv
// MSX cartridge-slot bus initiator: turns single-beat host requests into Z80-timed memory,
// M1 and I/O cycles. Define MSX_BUS_WAIT_EN to let responders stretch cycles through wait_n.
`timescale 1ns/1ps

module msx_bus_master #(
  parameter int unsigned CLK_DIV        = 6,
  parameter logic [3:0]  SLOT_PAGE_MASK = 4'b0110
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic        req_write,
  input  logic        req_io,
  input  logic        req_m1,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] addr,
  output logic [7:0]  cdout,
  input  logic [7:0]  cdin,
  output logic        cd_oe,
  output logic        merq_n,
  output logic        iorq_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        m1_n,
  output logic        sltsl_n,
  input  logic        wait_n
);

  localparam int unsigned    CW    = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  TLAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_TW, S_T3, S_T4, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_MEM_RD, OP_MEM_WR, OP_M1, OP_IO_RD, OP_IO_WR
  } op_e;

  typedef struct packed {
    logic merq_n;
    logic iorq_n;
    logic rd_n;
    logic wr_n;
    logic m1_n;
    logic sltsl_n;
    logic cd_oe;
  } bus_ctl_t;

  localparam bus_ctl_t CTL_IDLE = '{merq_n: 1'b1, iorq_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1,
                                    m1_n: 1'b1, sltsl_n: 1'b1, cd_oe: 1'b0};

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic          sel_q, sel_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  bus_ctl_t      ctl_q, ctl_d;
  logic          rsp_valid_q;
  logic [7:0]    rdata_q;
  logic [15:0]   addr_q;
  logic [7:0]    cdout_q;
  logic          tlast;
  logic          wait_stall;
  logic          accept;

`ifdef MSX_BUS_WAIT_EN
  assign wait_stall = ~wait_n;
`else
  logic unused_wait_n;
  assign unused_wait_n = wait_n;
  assign wait_stall    = 1'b0;
`endif

  assign tlast     = (tcnt_q == TLAST);
  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;

  function automatic op_e decode_op(input logic write, input logic io, input logic m1);
    if (io)    return write ? OP_IO_WR : OP_IO_RD;
    if (write) return OP_MEM_WR;
    return m1 ? OP_M1 : OP_MEM_RD;
  endfunction

  // Strobe pattern for the state the bus is about to enter; registered so outputs are glitch-free.
  function automatic bus_ctl_t ctl_for(input state_e s, input op_e op, input logic sel);
    bus_ctl_t c;
    logic     strobe;
    logic     drive;
    c      = CTL_IDLE;
    strobe = (s == S_T2) || (s == S_TW) || (s == S_T3);
    drive  = (s == S_T1) || strobe;
    unique case (op)
      OP_MEM_RD: if (strobe) begin
        c.merq_n  = 1'b0;
        c.rd_n    = 1'b0;
        c.sltsl_n = ~sel;
      end
      OP_MEM_WR: begin
        c.cd_oe = drive;
        if (strobe) begin
          c.merq_n  = 1'b0;
          c.wr_n    = 1'b0;
          c.sltsl_n = ~sel;
        end
      end
      OP_M1: begin
        c.m1_n = ~((s == S_T1) || (s == S_T2) || (s == S_TW));
        if (strobe) begin
          c.merq_n  = 1'b0;
          c.rd_n    = 1'b0;
          c.sltsl_n = ~sel;
        end
      end
      OP_IO_RD: if (strobe) begin
        c.iorq_n = 1'b0;
        c.rd_n   = 1'b0;
      end
      OP_IO_WR: begin
        c.cd_oe = drive;
        if (strobe) begin
          c.iorq_n = 1'b0;
          c.wr_n   = 1'b0;
        end
      end
      default: c = CTL_IDLE;
    endcase
    return c;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    state_d = state_q;
    op_d    = op_q;
    sel_d   = sel_q;
    tcnt_d  = '0;
    unique case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = S_T1;
        op_d    = decode_op(req_write, req_io, req_m1);
        sel_d   = ~req_io & SLOT_PAGE_MASK[req_addr[15:14]];
      end
      S_T1:   if (tlast) state_d = S_T2;
      S_T2:   if (tlast) state_d = ((op_q == OP_IO_RD) || (op_q == OP_IO_WR) || wait_stall)
                                   ? S_TW : S_T3;
      S_TW:   if (tlast) state_d = wait_stall ? S_TW : S_T3;
      S_T3:   if (tlast) state_d = (op_q == OP_M1) ? S_T4 : S_DONE;
      S_T4:   if (tlast) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if ((state_q != S_IDLE) && (state_q != S_DONE) && !tlast)
      tcnt_d = tcnt_q + CW'(1);
    ctl_d = ctl_for(state_d, op_d, sel_d);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_MEM_RD;
      sel_q       <= 1'b0;
      tcnt_q      <= '0;
      ctl_q       <= CTL_IDLE;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
      addr_q      <= 16'h0000;
      cdout_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sel_q       <= sel_d;
      tcnt_q      <= tcnt_d;
      ctl_q       <= ctl_d;
      rsp_valid_q <= (state_d == S_DONE);
      if (accept) begin
        addr_q  <= req_io ? {8'h00, req_addr[7:0]} : req_addr;
        cdout_q <= req_wdata;
      end
      if ((state_q == S_T3) && tlast &&
          ((op_q == OP_MEM_RD) || (op_q == OP_M1) || (op_q == OP_IO_RD)))
        rdata_q <= cdin;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign addr      = addr_q;
  assign cdout     = cdout_q;
  assign cd_oe     = ctl_q.cd_oe;
  assign merq_n    = ctl_q.merq_n;
  assign iorq_n    = ctl_q.iorq_n;
  assign rd_n      = ctl_q.rd_n;
  assign wr_n      = ctl_q.wr_n;
  assign m1_n      = ctl_q.m1_n;
  assign sltsl_n   = ctl_q.sltsl_n;

endmodule
